// File: rtl/fifo_rr_arbiter.sv
// Round-robin merge of N FWFT FIFO read ports onto one registered FIFO write port.
// Define FIFO_ARB_BURST_LOCK_EN to hold each grant for up to BURST_LEN words; otherwise one word per grant.
module fifo_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_PORTS    = 4,
  parameter int SEL_WIDTH  = $clog2(N_PORTS),
  parameter int BURST_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_PORTS-1:0]            in_empty_n,
  output logic [N_PORTS-1:0]            in_read,
  input  logic [N_PORTS*DATA_WIDTH-1:0] in_dout,
  input  logic                          out_full_n,
  output logic                          out_write,
  output logic [DATA_WIDTH-1:0]         out_din,
  output logic [SEL_WIDTH-1:0]          out_sel
);

  localparam int unsigned NP = N_PORTS;

  if (N_PORTS < 2 || N_PORTS > 16 || BURST_LEN < 1) begin : g_param_check
    $error("fifo_rr_arbiter: N_PORTS must be 2..16 and BURST_LEN >= 1");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nx;
  logic [SEL_WIDTH-1:0] grant, grant_nx;
  logic [SEL_WIDTH-1:0] ptr, ptr_nx;
  logic [SEL_WIDTH-1:0] winner;
  logic                 found;
  logic                 xfer;
  logic                 release_g;
  int unsigned          cand;

`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);
  logic [CNT_W-1:0] cnt, cnt_nx;
`endif

  // Rotating scan from ptr; wrap by subtraction keeps non-power-of-2 port counts in range.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 0; i < NP; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= NP) cand = cand - NP;
      if (!found && in_empty_n[SEL_WIDTH'(cand)]) begin
        found  = 1'b1;
        winner = SEL_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    ptr_nx    = ptr;
    in_read   = '0;
    xfer      = 1'b0;
    release_g = 1'b0;
`ifdef FIFO_ARB_BURST_LOCK_EN
    cnt_nx    = cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = winner;
          state_nx = BUSY;
`ifdef FIFO_ARB_BURST_LOCK_EN
          cnt_nx   = '0;
`endif
        end
      end
      BUSY: begin
        xfer           = in_empty_n[grant] & out_full_n;
        in_read[grant] = xfer;
`ifdef FIFO_ARB_BURST_LOCK_EN
        release_g = (xfer && (cnt == CNT_W'(BURST_LEN - 1))) || !in_empty_n[grant];
        if (xfer && !release_g) cnt_nx = cnt + 1'b1;
`else
        release_g = xfer || !in_empty_n[grant];
`endif
        if (release_g) begin
          state_nx = IDLE;
          ptr_nx   = (grant == SEL_WIDTH'(NP - 1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
      out_write <= 1'b0;
      out_din   <= '0;
      out_sel   <= '0;
`ifdef FIFO_ARB_BURST_LOCK_EN
      cnt       <= '0;
`endif
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      ptr       <= ptr_nx;
      out_write <= xfer;
      if (xfer) begin
        out_din <= in_dout[grant*DATA_WIDTH +: DATA_WIDTH];
        out_sel <= grant;
      end
`ifdef FIFO_ARB_BURST_LOCK_EN
      cnt       <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench for fifo_rr_arbiter: queue-based upstream FIFOs and a transaction-level arbitration model.
module tb_fifo_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = $clog2(N);
  localparam int BL = 8;
`ifdef FIFO_ARB_BURST_LOCK_EN
  localparam int EFF = BL;
`else
  localparam int EFF = 1;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    in_empty_n;
  logic [N-1:0]    in_read;
  logic [N*DW-1:0] in_dout;
  logic            out_full_n;
  logic            out_write;
  logic [DW-1:0]   out_din;
  logic [SW-1:0]   out_sel;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .DATA_WIDTH(DW),
    .N_PORTS(N),
    .SEL_WIDTH(SW),
    .BURST_LEN(BL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_empty_n(in_empty_n),
    .in_read(in_read),
    .in_dout(in_dout),
    .out_full_n(out_full_n),
    .out_write(out_write),
    .out_din(out_din),
    .out_sel(out_sel)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q [N][$];
  int            push_cnt [N];
  bit            rst_req;
  bit            full_req;

  // transaction-level model: which port owns the output, words moved in this grant, next scan start
  int            m_owner;
  int            m_taken;
  int            m_next;
  bit            m_write;
  logic [DW-1:0] m_din;
  int            m_sel;

  bit            prev_full;
  int            samp;
  bit            log_en;
  int            wr_at[$];
  int            wr_sel[$];
  logic [DW-1:0] wr_din[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      q[k].push_back(DW'((k << 24) | push_cnt[k]));
      push_cnt[k]++;
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      in_empty_n[k] = (q[k].size() != 0);
      in_dout[k*DW +: DW] = (q[k].size() != 0) ? q[k][0] : DW'(32'hBAD0_0000 | k);
    end
  endtask

  function automatic logic [N-1:0] exp_read_f();
    logic [N-1:0] r;
    r = '0;
    if (m_owner >= 0 && q[m_owner].size() != 0 && out_full_n) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_taken = 0;
    m_next  = 0;
    m_write = 1'b0;
    m_din   = '0;
    m_sel   = 0;
  endtask

  task automatic model_step();
    bit xfer;
    bit valid_o;
    bit done;
    if (m_owner < 0) begin
      m_write = 1'b0;
      done = 1'b0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_next + i) % N;
        if (!done && q[k].size() != 0) begin
          m_owner = k;
          m_taken = 0;
          done = 1'b1;
        end
      end
    end else begin
      valid_o = (q[m_owner].size() != 0);
      xfer    = valid_o && out_full_n;
      m_write = xfer;
      if (xfer) begin
        m_din = q[m_owner].pop_front();
        m_sel = m_owner;
        m_taken++;
      end
      if ((xfer && m_taken == EFF) || !valid_o) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic compare_all();
    chk("in_read", 64'(in_read), 64'(exp_read_f()));
    chk("out_write", 64'(out_write), 64'(m_write));
    chk("out_din", 64'(out_din), 64'(m_din));
    chk("out_sel", 64'(out_sel), 64'(m_sel));
    if (!out_full_n) chk("read_while_full_low", 64'(in_read), 64'd0);
    if (!prev_full) chk("write_after_full_low", 64'(out_write), 64'd0);
    prev_full = out_full_n || !reset_n;
    if (log_en && out_write === 1'b1) begin
      wr_at.push_back(samp);
      wr_sel.push_back(int'(out_sel));
      wr_din.push_back(out_din);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    reset_n    = rst_req;
    out_full_n = full_req;
    drive_inputs();
    #1;
    if (!reset_n) model_reset();
    compare_all();
    if (reset_n) model_step();
    samp++;
  endtask

  task automatic clear_log();
    wr_at.delete();
    wr_sel.delete();
    wr_din.delete();
    samp = 0;
  endtask

  function automatic bit busy_f();
    bit b;
    b = (m_owner >= 0) || m_write;
    for (int k = 0; k < N; k++) if (q[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string nm);
    int n;
    n = 0;
    full_req = 1'b1;
    while (busy_f() && n < 600) begin
      cycle();
      n++;
    end
    chk({nm, "_drained"}, 64'(n < 600), 64'd1);
  endtask

  task automatic reset_pulse();
    rst_req = 1'b0;
    cycle();
    cycle();
    rst_req = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) push_cnt[k] = 0;
    model_reset();
    reset_n    = 1'b0;
    rst_req    = 1'b0;
    full_req   = 1'b1;
    out_full_n = 1'b1;
    in_empty_n = '0;
    in_dout    = '0;
    prev_full  = 1'b1;
    log_en     = 1'b0;
    samp       = 0;

    // reset held with every port valid, then fair rotation over 64 words per port
    for (int k = 0; k < N; k++) push(k, 64);
    repeat (3) begin
      cycle();
      chk("rst_out_write", 64'(out_write), 64'd0);
      chk("rst_in_read", 64'(in_read), 64'd0);
      chk("rst_out_din", 64'(out_din), 64'd0);
    end
    rst_req = 1'b1;
    clear_log();
    log_en = 1'b1;
    repeat (2 + 256 + 256 / EFF + 4) cycle();
    log_en = 1'b0;
    chk("fair_count", 64'(wr_at.size()), 64'd256);
    for (int k = 0; k < wr_at.size() && k < 256; k++) begin
      chk("fair_slot", 64'(wr_at[k]), 64'(2 + k + k / EFF));
      chk("fair_sel", 64'(wr_sel[k]), 64'((k / EFF) % N));
      chk("fair_data", 64'(wr_din[k]),
          64'((((k / EFF) % N) << 24) | ((k / (EFF * N)) * EFF + k % EFF)));
    end

    // early release: lone port 2 with 3 words, then the pointer must sit at 3
    reset_pulse();
    clear_log();
    push(2, 3);
    log_en = 1'b1;
    repeat (12) cycle();
    log_en = 1'b0;
    chk("early_count", 64'(wr_sel.size()), 64'd3);
    for (int i = 0; i < wr_sel.size() && i < 3; i++) begin
      chk("early_sel", 64'(wr_sel[i]), 64'd2);
      chk("early_data", 64'(wr_din[i]), 64'((2 << 24) | (64 + i)));
    end
    clear_log();
    push(0, 2);
    push(3, 2);
    log_en = 1'b1;
    repeat (6) cycle();
    log_en = 1'b0;
    chk("ptr_next_count", 64'(wr_sel.size() > 0), 64'd1);
    if (wr_sel.size() > 0) chk("ptr_next_sel", 64'(wr_sel[0]), 64'd3);
    drain("early");

    // backpressure: two 5-cycle drops of out_full_n in the middle of bursts
    reset_pulse();
    for (int k = 0; k < N; k++) push(k, 40);
    for (int s = 0; s < 60; s++) begin
      full_req = !((s >= 6 && s < 11) || (s >= 23 && s < 28));
      cycle();
    end
    drain("backpressure");

    // randomized traffic and backpressure
    for (int s = 0; s < 800; s++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 3) == 0 && q[k].size() < 16) push(k, int'($urandom_range(1, 3)));
      full_req = ($urandom_range(0, 4) != 0);
      cycle();
    end
    drain("random");

    // asynchronous reset in the middle of a port-1 burst
    reset_pulse();
    clear_log();
    push(1, 12);
    log_en = 1'b1;
    for (int s = 0; s < 60 && wr_sel.size() < 4; s++) cycle();
    log_en = 1'b0;
    chk("mid_reached", 64'(wr_sel.size()), 64'd4);
    push(3, 4);
    @(negedge clk);
    reset_n    = rst_req;
    out_full_n = full_req;
    drive_inputs();
    #1;
    compare_all();
    rst_req = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("async_out_write", 64'(out_write), 64'd0);
    chk("async_out_din", 64'(out_din), 64'd0);
    chk("async_out_sel", 64'(out_sel), 64'd0);
    chk("async_in_read", 64'(in_read), 64'd0);
    model_reset();
    prev_full = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b1;
    clear_log();
    log_en = 1'b1;
    repeat (4) cycle();
    log_en = 1'b0;
    chk("post_reset_count", 64'(wr_sel.size() > 0), 64'd1);
    if (wr_sel.size() > 0) chk("post_reset_sel", 64'(wr_sel[0]), 64'd1);
    drain("mid_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
